// File: rtl/fetch_line_buffer_if.sv
// CPU-side fetch bus and ROM read port of the instruction fetch line buffer.
interface fetch_line_buffer_if #(
    parameter int unsigned LINE_ADDR_WIDTH = 5
);
    logic [31:0]                  pc;
    logic                         fetch_req;
    logic                         invalidate;
    logic [31:0]                  instr;
    logic                         instr_valid;
    logic                         stall;
    logic                         addr_error;
    logic [LINE_ADDR_WIDTH-1:0]   rom_address;
    logic [127:0]                 rom_data;
    logic [15:0]                  miss_count;

    // CPU + ROM side: drives requests and ROM read data.
    modport master (
        output pc, fetch_req, invalidate, rom_data,
        input  instr, instr_valid, stall, addr_error, rom_address, miss_count
    );

    // Line buffer side.
    modport slave (
        input  pc, fetch_req, invalidate, rom_data,
        output instr, instr_valid, stall, addr_error, rom_address, miss_count
    );
endinterface

// File: rtl/fetch_line_buffer.sv
// Single-line instruction buffer in front of a 128-bit synchronous ROM.
// Serves 32-bit words by byte PC with zero-cycle hit latency and fills the
// line from the ROM on a miss, stalling the CPU for three cycles.
module fetch_line_buffer #(
    parameter int unsigned LINE_ADDR_WIDTH = 5,
    parameter logic [31:0] OOR_INSTR       = 32'h1000ffff,
    parameter logic [31:0] NOP_INSTR       = 32'h00000020
) (
    input logic                clock,
    input logic                reset,
    fetch_line_buffer_if.slave bus
);
    localparam int unsigned RangeLo = LINE_ADDR_WIDTH + 4;

    typedef enum logic [1:0] {StIdle, StAddr, StCapture} state_t;

    state_t                     state;
    logic                       line_valid;
    logic [LINE_ADDR_WIDTH-1:0] line_tag;
    logic [127:0]               line_data;
    logic [LINE_ADDR_WIDTH-1:0] rom_address;
    logic [15:0]                miss_count;

    logic [1:0]                 word_sel;
    logic [6:0]                 word_base;
    logic [LINE_ADDR_WIDTH-1:0] line_sel;
    logic                       misaligned;
    logic                       out_of_range;
    logic                       hit;
    logic                       start_fill;

    assign word_sel     = bus.pc[3:2];
    assign word_base    = {word_sel, 5'd0};
    assign line_sel     = bus.pc[RangeLo-1:4];
    assign misaligned   = bus.pc[1:0] != 2'b00;
    assign out_of_range = bus.pc[31:RangeLo] != '0;
    assign hit          = line_valid && (line_tag == line_sel);

    assign bus.rom_address = rom_address;
    assign bus.miss_count  = miss_count;

    // Request decode: error, out-of-range, hit, miss in priority order; busy while filling.
    always_comb begin
        bus.instr       = NOP_INSTR;
        bus.instr_valid = 1'b0;
        bus.stall       = 1'b0;
        bus.addr_error  = 1'b0;
        start_fill      = 1'b0;
        if (state == StIdle) begin
            if (bus.fetch_req) begin
                if (misaligned) begin
                    bus.addr_error = 1'b1;
                end else if (out_of_range) begin
                    bus.instr       = OOR_INSTR;
                    bus.instr_valid = 1'b1;
                end else if (hit) begin
                    bus.instr       = line_data[word_base +: 32];
                    bus.instr_valid = 1'b1;
                end else begin
                    bus.stall  = 1'b1;
                    start_fill = 1'b1;
                end
            end
        end else begin
            bus.stall = bus.fetch_req;
        end
    end

    // Fill sequencer: latch line address, let the ROM register it, then capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= StIdle;
            line_valid  <= 1'b0;
            line_tag    <= '0;
            line_data   <= '0;
            rom_address <= '0;
            miss_count  <= '0;
        end else if (bus.invalidate) begin
            // Aborts any fill in flight; the pending ROM read is simply dropped.
            line_valid <= 1'b0;
            state      <= StIdle;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start_fill) begin
                        rom_address <= line_sel;
                        if (miss_count != 16'hffff) begin
                            miss_count <= miss_count + 16'd1;
                        end
                        state <= StAddr;
                    end
                end
                StAddr: begin
                    state <= StCapture;
                end
                StCapture: begin
                    line_data  <= bus.rom_data;
                    line_tag   <= rom_address;
                    line_valid <= 1'b1;
                    state      <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_line_buffer.sv
// Bench for fetch_line_buffer: directed test-plan steps followed by random
// requests, all checked against a cycle-level behavioural model.
module tb_fetch_line_buffer;
    localparam logic [31:0] OOR = 32'h1000ffff;
    localparam logic [31:0] NOP = 32'h00000020;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    logic [127:0] rom_mem [32];

    fetch_line_buffer_if #(.LINE_ADDR_WIDTH(5)) bus ();

    fetch_line_buffer #(
        .LINE_ADDR_WIDTH(5),
        .OOR_INSTR      (OOR),
        .NOP_INSTR      (NOP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // Synchronous ROM: output registered from the sampled line address.
    always @(posedge clock) bus.rom_data <= rom_mem[bus.rom_address];

    // Reference model: which line is held, and how many edges remain in a fill.
    bit          m_valid;
    int          m_line;
    int          m_left;
    logic [4:0]  m_rom_addr;
    logic [15:0] m_misses;

    function automatic logic [31:0] rom_word(input int line, input int w);
        logic [127:0] l;
        l = rom_mem[line];
        return l[32*w +: 32];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid    = 1'b0;
        m_line     = 0;
        m_left     = 0;
        m_rom_addr = '0;
        m_misses   = '0;
    endtask

    // Apply one cycle of inputs, check outputs mid-cycle, advance the model past the edge.
    task automatic step(input logic [31:0] p, input logic req, input logic inv, input logic rst);
        logic [31:0] e_instr;
        logic        e_valid, e_stall, e_err, miss;
        int          line, w;
        @(negedge clock);
        bus.pc         = p;
        bus.fetch_req  = req;
        bus.invalidate = inv;
        reset          = rst;
        #1;
        line    = int'(p[8:4]);
        w       = int'(p[3:2]);
        e_instr = NOP;
        e_valid = 1'b0;
        e_stall = 1'b0;
        e_err   = 1'b0;
        miss    = 1'b0;
        if (m_left != 0) begin
            e_stall = req;
        end else if (req) begin
            if (p[1:0] != 0) e_err = 1'b1;
            else if (p >= 32'd512) begin
                e_instr = OOR;
                e_valid = 1'b1;
            end else if (m_valid && m_line == line) begin
                e_instr = rom_word(line, w);
                e_valid = 1'b1;
            end else begin
                e_stall = 1'b1;
                miss    = 1'b1;
            end
        end
        check("instr", bus.instr, e_instr);
        check("instr_valid", 32'(bus.instr_valid), 32'(e_valid));
        check("stall", 32'(bus.stall), 32'(e_stall));
        check("addr_error", 32'(bus.addr_error), 32'(e_err));
        check("rom_address", 32'(bus.rom_address), 32'(m_rom_addr));
        check("miss_count", 32'(bus.miss_count), 32'(m_misses));
        if (rst) begin
            model_reset();
        end else if (inv) begin
            m_valid = 1'b0;
            m_left  = 0;
        end else if (m_left == 0) begin
            if (miss) begin
                m_rom_addr = p[8:4];
                if (m_misses != 16'hffff) m_misses = m_misses + 16'd1;
                m_left = 2;
            end
        end else if (m_left == 2) begin
            m_left = 1;
        end else begin
            m_valid = 1'b1;
            m_line  = int'(m_rom_addr);
            m_left  = 0;
        end
    endtask

    initial begin
        logic [31:0] p;
        logic        req, inv, rst;
        for (int i = 0; i < 32; i++) begin
            rom_mem[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        rom_mem[0][31:0]   = 32'h00000020;
        rom_mem[0][63:32]  = 32'h0080f820;
        rom_mem[0][95:64]  = 32'h00bf1019;
        rom_mem[1][31:0]   = 32'h00001820;
        rom_mem[1][127:96] = 32'h10c0000c;
        rom_mem[2][31:0]   = 32'h8c6d0000;

        bus.pc         = '0;
        bus.fetch_req  = 1'b0;
        bus.invalidate = 1'b0;
        repeat (2) @(posedge clock);
        model_reset();

        // Reset state
        step(32'h0, 1'b0, 1'b0, 1'b1);
        check("rst_instr", bus.instr, NOP);
        check("rst_miss_count", 32'(bus.miss_count), 32'd0);

        // 1: cold miss, then line-0 hits
        repeat (3) step(32'h0, 1'b1, 1'b0, 1'b0);
        check("tp1_rom_address", 32'(bus.rom_address), 32'd0);
        step(32'h0, 1'b1, 1'b0, 1'b0);
        check("tp1_w0", bus.instr, 32'h00000020);
        check("tp1_w0_valid", 32'(bus.instr_valid), 32'd1);
        step(32'h4, 1'b1, 1'b0, 1'b0);
        check("tp1_w1", bus.instr, 32'h0080f820);
        step(32'h8, 1'b1, 1'b0, 1'b0);
        check("tp1_w2", bus.instr, 32'h00bf1019);
        check("tp1_miss_count", 32'(bus.miss_count), 32'd1);

        // 2: line change
        repeat (3) step(32'h10, 1'b1, 1'b0, 1'b0);
        step(32'h10, 1'b1, 1'b0, 1'b0);
        check("tp2_w0", bus.instr, 32'h00001820);
        check("tp2_rom_address", 32'(bus.rom_address), 32'd1);
        step(32'h1c, 1'b1, 1'b0, 1'b0);
        check("tp2_w3", bus.instr, 32'h10c0000c);
        check("tp2_miss_count", 32'(bus.miss_count), 32'd2);

        // 3: out of range, 4: misaligned
        step(32'h200, 1'b1, 1'b0, 1'b0);
        check("tp3_instr", bus.instr, 32'h1000ffff);
        check("tp3_stall", 32'(bus.stall), 32'd0);
        step(32'h6, 1'b1, 1'b0, 1'b0);
        check("tp4_addr_error", 32'(bus.addr_error), 32'd1);
        step(32'h6, 1'b0, 1'b0, 1'b0);
        check("tp4_no_fill", 32'(bus.miss_count), 32'd2);

        // 5: invalidate in ADDR, then refill line 2
        step(32'h20, 1'b1, 1'b0, 1'b0);
        step(32'h20, 1'b1, 1'b1, 1'b0);
        repeat (3) step(32'h20, 1'b1, 1'b0, 1'b0);
        step(32'h20, 1'b1, 1'b0, 1'b0);
        check("tp5_w0", bus.instr, 32'h8c6d0000);
        check("tp5_miss_count", 32'(bus.miss_count), 32'd4);
        // 5b: reset mid-fill
        step(32'h30, 1'b1, 1'b0, 1'b0);
        step(32'h30, 1'b1, 1'b0, 1'b1);
        step(32'h30, 1'b0, 1'b0, 1'b0);
        check("tp5_rst_miss_count", 32'(bus.miss_count), 32'd0);
        check("tp5_rst_rom_address", 32'(bus.rom_address), 32'd0);

        // 6: line 1 then back to line 0
        repeat (4) step(32'h14, 1'b1, 1'b0, 1'b0);
        step(32'h0, 1'b1, 1'b0, 1'b0);
        check("tp6_miss", 32'(bus.stall), 32'd1);
        repeat (2) step(32'h0, 1'b1, 1'b0, 1'b0);
        step(32'h4, 1'b1, 1'b0, 1'b0);
        check("tp6_w1", bus.instr, 32'h0080f820);

        // Random traffic
        p = 32'h0;
        for (int i = 0; i < 800; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (!(bus.stall && $urandom_range(0, 9) < 8)) begin
                if (r < 5) p = $urandom | 32'h1;
                else if (r < 10) p = ($urandom & ~32'h3) | 32'h200;
                else if (r < 20) p = {23'd0, 5'($urandom), 2'($urandom), 2'b00};
                else p = {23'd0, 5'($urandom_range(0, 3)), 2'($urandom), 2'b00};
            end
            req = ($urandom_range(0, 99) < 85);
            inv = ($urandom_range(0, 99) < 3);
            rst = ($urandom_range(0, 99) < 1);
            step(p, req, inv, rst);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
